cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 36 +++
 rtl/cdb_arbiter_if.sv | 29 ++
 rtl/cdb_rr_picker.sv | 32 +++
 rtl/cdb_arbiter.sv | 113 +++++++++++
 tb/tb_cdb_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared lane-count macros, CDB lane types and the modulo scan helper
// used by the arbiter and its picker.
`ifndef NUM_CDB_LANES
`define NUM_CDB_LANES 2
`endif
`ifndef NUM_CDB_SRC
`define NUM_CDB_SRC 8
`endif

package cdb_arbiter_pkg;

  // Lane fields are sized for the widest supported configuration.
  // Narrower instances cast into and out of these fields.
  localparam int CDB_TAG_W  = 8;
  localparam int CDB_DATA_W = 64;
  localparam int CDB_SRC_W  = 4;

  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
    logic [CDB_SRC_W-1:0]  src;
  } cdb_entry_t;

  typedef cdb_entry_t [`NUM_CDB_LANES-1:0] cdb_t;

  // Modulo add without a divider. Valid when base < n and off <= n,
  // which always holds for the scan offsets and the pointer increment.
  function automatic int wrap_add(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    if (sum >= n) sum = sum - n;
    return sum;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side handshake and CDB broadcast lanes.
// The master modport is the arbiter; the slave modport is producers and consumers.
interface cdb_arbiter_if #(
  parameter int N_SRC   = 8,
  parameter int NUM_BUS = 2,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32,
  parameter int SRC_W   = $clog2(N_SRC)
);
  logic                             flush;
  logic [N_SRC-1:0]                 src_valid;
  logic [N_SRC-1:0][TAG_W-1:0]      src_tag;
  logic [N_SRC-1:0][DATA_W-1:0]     src_data;
  logic [N_SRC-1:0]                 src_ready;
  logic [NUM_BUS-1:0]               cdb_valid;
  logic [NUM_BUS-1:0][TAG_W-1:0]    cdb_tag;
  logic [NUM_BUS-1:0][DATA_W-1:0]   cdb_data;
  logic [NUM_BUS-1:0][SRC_W-1:0]    cdb_src;

  modport master (
    input  flush, src_valid, src_tag, src_data,
    output src_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );

  modport slave (
    output flush, src_valid, src_tag, src_data,
    input  src_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );
endinterface

// File: rtl/cdb_rr_picker.sv
// One-of-N priority picker: grants the first set bit of mask found when
// scanning upward from start, wrapping modulo N_SRC.
module cdb_rr_picker
  import cdb_arbiter_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int SRC_W = $clog2(N_SRC)
) (
  input  logic [SRC_W-1:0] start,
  input  logic [N_SRC-1:0] mask,
  output logic [N_SRC-1:0] gnt,
  output logic [SRC_W-1:0] gnt_idx,
  output logic             gnt_any
);

  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = wrap_add(int'(start), k, N_SRC);
      if (!gnt_any && mask[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = SRC_W'(idx);
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting up to NUM_BUS producers per cycle onto the
// common data bus, with registered single-cycle lane pulses.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_SRC   = `NUM_CDB_SRC,
  parameter int NUM_BUS = `NUM_CDB_LANES,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  cdb_arbiter_if.master     bus,
  output logic [31:0]       stall_cnt
);

  localparam int SRC_W = $clog2(N_SRC);

  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] rr_next;
  logic [31:0]      stall_q;
  logic [N_SRC-1:0] ready;
  logic             stall_evt;

  logic [N_SRC-1:0] mask    [NUM_BUS];
  logic [N_SRC-1:0] gnt     [NUM_BUS];
  logic [SRC_W-1:0] gnt_idx [NUM_BUS];
  logic             gnt_any [NUM_BUS];

  cdb_entry_t lane_d [NUM_BUS];
  cdb_entry_t lane_q [NUM_BUS];

  // Flush and reset both remove every request before the picker chain.
  assign mask[0] = (bus.flush || rst) ? '0 : bus.src_valid;

  // Each picker sees the requests left over by the lanes before it, so
  // scanning from the same pointer yields the next source in scan order.
  for (genvar b = 0; b < NUM_BUS; b++) begin : g_lane
    cdb_rr_picker #(
      .N_SRC (N_SRC),
      .SRC_W (SRC_W)
    ) u_picker (
      .start   (rr_ptr),
      .mask    (mask[b]),
      .gnt     (gnt[b]),
      .gnt_idx (gnt_idx[b]),
      .gnt_any (gnt_any[b])
    );
    if (b < NUM_BUS - 1) begin : g_chain
      assign mask[b+1] = mask[b] & ~gnt[b];
    end
  end

  always_comb begin
    ready   = '0;
    rr_next = rr_ptr;
    for (int b = 0; b < NUM_BUS; b++) begin
      ready = ready | gnt[b];
      if (gnt_any[b]) rr_next = SRC_W'(wrap_add(int'(gnt_idx[b]), 1, N_SRC));
    end
  end

  assign bus.src_ready = ready;
  assign stall_evt     = !bus.flush && ((bus.src_valid & ~ready) != '0);

  always_comb begin
    for (int b = 0; b < NUM_BUS; b++) begin
      lane_d[b] = '0;
      if (gnt_any[b]) begin
        lane_d[b].valid = 1'b1;
        lane_d[b].tag   = CDB_TAG_W'(bus.src_tag[gnt_idx[b]]);
        lane_d[b].data  = CDB_DATA_W'(bus.src_data[gnt_idx[b]]);
        lane_d[b].src   = CDB_SRC_W'(gnt_idx[b]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_BUS; b++) lane_q[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BUS; b++) lane_q[b] <= lane_d[b];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr  <= '0;
      stall_q <= '0;
    end else if (bus.flush) begin
      rr_ptr  <= '0;
    end else begin
      rr_ptr <= rr_next;
      if (stall_evt && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;

  always_comb begin
    bus.cdb_valid = '0;
    bus.cdb_tag   = '0;
    bus.cdb_data  = '0;
    bus.cdb_src   = '0;
    for (int b = 0; b < NUM_BUS; b++) begin
      bus.cdb_valid[b] = lane_q[b].valid;
      bus.cdb_tag[b]   = TAG_W'(lane_q[b].tag);
      bus.cdb_data[b]  = DATA_W'(lane_q[b].data);
      bus.cdb_src[b]   = SRC_W'(lane_q[b].src);
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: an 8-source and a 5-source instance,
// directed vectors with hand-computed grants, lanes checked by monitors.
module tb_cdb_arbiter;

  typedef struct packed {
    logic [1:0]       valid;
    logic [1:0][2:0]  src;
    logic [1:0][3:0]  tag;
    logic [1:0][31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] stall8;
  logic [31:0] stall5;

  int n_total;
  int n_pass;

  exp_t q8[$];
  exp_t q5[$];
  exp_t act8, exp8, act5, exp5;

  cdb_arbiter_if #(.N_SRC(8), .NUM_BUS(2), .TAG_W(4), .DATA_W(32)) bus8 ();
  cdb_arbiter_if #(.N_SRC(5), .NUM_BUS(2), .TAG_W(4), .DATA_W(32)) bus5 ();

  cdb_arbiter #(.N_SRC(8), .NUM_BUS(2), .TAG_W(4), .DATA_W(32)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus8.master),
    .stall_cnt (stall8)
  );

  cdb_arbiter #(.N_SRC(5), .NUM_BUS(2), .TAG_W(4), .DATA_W(32)) dut5 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus5.master),
    .stall_cnt (stall5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] tagOf(input int d, input int i);
    return (d == 0) ? 4'((i * 3 + 1) % 16) : 4'((i + 9) % 16);
  endfunction

  function automatic logic [31:0] dataOf(input int d, input int i);
    return (d == 0) ? 32'hA500_0000 + 32'(i * 17) : 32'h5A00_0000 + 32'(i);
  endfunction

  function automatic exp_t mkExp(input int d, input int s0, input int s1);
    exp_t e;
    e = '0;
    if (s0 >= 0) begin
      e.valid[0] = 1'b1; e.src[0] = 3'(s0); e.tag[0] = tagOf(d, s0); e.data[0] = dataOf(d, s0);
    end
    if (s1 >= 0) begin
      e.valid[1] = 1'b1; e.src[1] = 3'(s1); e.tag[1] = tagOf(d, s1); e.data[1] = dataOf(d, s1);
    end
    return e;
  endfunction

  function automatic exp_t maskLanes(input exp_t e);
    exp_t m;
    m = e;
    for (int b = 0; b < 2; b++) begin
      if (!m.valid[b]) begin
        m.src[b] = '0; m.tag[b] = '0; m.data[b] = '0;
      end
    end
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic checkLanes(input string name, input exp_t act, input exp_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got valid=%b src=%h tag=%h data=%h expected valid=%b src=%h tag=%h data=%h",
                  name, act.valid, act.src, act.tag, act.data, exp.valid, exp.src, exp.tag, exp.data);
  endtask

  // Drive one cycle on the 8-source instance, check grants, queue the lanes.
  task automatic applyStimulus(input logic [7:0] v, input logic fl, input logic [7:0] exp_ready,
                               input int s0, input int s1);
    @(posedge clk);
    #1;
    bus8.src_valid = v;
    bus8.flush     = fl;
    @(negedge clk);
    checkOutput("ready8", 32'(bus8.src_ready), 32'(exp_ready));
    if (s0 >= 0) q8.push_back(mkExp(0, s0, s1));
  endtask

  task automatic applyStimulus5(input logic [4:0] v, input logic [4:0] exp_ready,
                                input int s0, input int s1);
    @(posedge clk);
    #1;
    bus5.src_valid = v;
    bus5.flush     = 1'b0;
    @(negedge clk);
    checkOutput("ready5", 32'(bus5.src_ready), 32'(exp_ready));
    if (s0 >= 0) q5.push_back(mkExp(1, s0, s1));
  endtask

  always @(negedge clk) begin
    if (bus8.cdb_valid != 2'b00) begin
      act8 = maskLanes({bus8.cdb_valid, bus8.cdb_src, bus8.cdb_tag, bus8.cdb_data});
      if (q8.size() == 0) begin
        n_total++;
        $display("[TB] FAIL cdb8 unexpected lane: got valid=%b src=%h expected no lane", act8.valid, act8.src);
      end else begin
        exp8 = q8.pop_front();
        checkLanes("cdb8", act8, exp8);
      end
    end
  end

  always @(negedge clk) begin
    if (bus5.cdb_valid != 2'b00) begin
      act5 = maskLanes({bus5.cdb_valid, bus5.cdb_src, bus5.cdb_tag, bus5.cdb_data});
      if (q5.size() == 0) begin
        n_total++;
        $display("[TB] FAIL cdb5 unexpected lane: got valid=%b src=%h expected no lane", act5.valid, act5.src);
      end else begin
        exp5 = q5.pop_front();
        checkLanes("cdb5", act5, exp5);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b1;
    bus8.flush = 1'b0; bus8.src_valid = 8'hFF;
    bus5.flush = 1'b0; bus5.src_valid = 5'h1F;
    for (int i = 0; i < 8; i++) begin
      bus8.src_tag[i] = tagOf(0, i); bus8.src_data[i] = dataOf(0, i);
    end
    for (int i = 0; i < 5; i++) begin
      bus5.src_tag[i] = tagOf(1, i); bus5.src_data[i] = dataOf(1, i);
    end

    // Reset holds everything quiet even with every producer requesting.
    repeat (2) @(negedge clk);
    checkOutput("rst ready8", 32'(bus8.src_ready), 32'h0);
    checkOutput("rst ready5", 32'(bus5.src_ready), 32'h0);
    checkOutput("rst cdb_valid8", 32'(bus8.cdb_valid), 32'h0);
    checkOutput("rst stall8", stall8, 32'h0);
    checkOutput("rst rr8", 32'(dut8.rr_ptr), 32'h0);
    bus8.src_valid = 8'h00;
    bus5.src_valid = 5'h00;
    rst = 1'b0;

    // Sources 1/3/6 from rr=0.
    applyStimulus(8'h4A, 1'b0, 8'h0A, 1, 3);
    applyStimulus(8'h00, 1'b0, 8'h00, -1, -1);
    checkOutput("stall after 1/3/6", stall8, 32'd1);
    checkOutput("rr after 1/3/6", 32'(dut8.rr_ptr), 32'd4);

    // Flush with three sources valid.
    applyStimulus(8'h15, 1'b1, 8'h00, -1, -1);
    applyStimulus(8'hFF, 1'b0, 8'h03, 0, 1);
    checkOutput("cdb_valid after flush", 32'(bus8.cdb_valid), 32'h0);
    checkOutput("rr after flush", 32'(dut8.rr_ptr), 32'd0);
    checkOutput("stall after flush", stall8, 32'd1);

    // All eight held valid: pairs in scan order.
    applyStimulus(8'hFF, 1'b0, 8'h0C, 2, 3);
    checkOutput("stall pair0", stall8, 32'd2);
    applyStimulus(8'hFF, 1'b0, 8'h30, 4, 5);
    applyStimulus(8'hFF, 1'b0, 8'hC0, 6, 7);
    checkOutput("stall pair2", stall8, 32'd4);

    // Single requester: granted alone, stall_cnt holds.
    applyStimulus(8'h80, 1'b0, 8'h80, 7, -1);
    checkOutput("rr after all pairs", 32'(dut8.rr_ptr), 32'd0);
    checkOutput("stall pair3", stall8, 32'd5);
    applyStimulus(8'h00, 1'b0, 8'h00, -1, -1);
    checkOutput("stall single", stall8, 32'd5);
    checkOutput("rr single", 32'(dut8.rr_ptr), 32'd0);

    // Saturation from 0xFFFFFFFE.
    force dut8.stall_q = 32'hFFFF_FFFE;
    #1;
    release dut8.stall_q;
    applyStimulus(8'hFF, 1'b0, 8'h03, 0, 1);
    checkOutput("stall preload", stall8, 32'hFFFF_FFFE);
    applyStimulus(8'hFF, 1'b0, 8'h0C, 2, 3);
    checkOutput("stall sat1", stall8, 32'hFFFF_FFFF);
    applyStimulus(8'hFF, 1'b0, 8'h30, 4, 5);
    checkOutput("stall sat2", stall8, 32'hFFFF_FFFF);

    // Reset lands on a granted cycle; that transfer must vanish.
    applyStimulus(8'hFF, 1'b0, 8'hC0, -1, -1);
    checkOutput("stall sat3", stall8, 32'hFFFF_FFFF);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid rst cdb_valid", 32'(bus8.cdb_valid), 32'h0);
    checkOutput("mid rst stall", stall8, 32'h0);
    checkOutput("mid rst ready", 32'(bus8.src_ready), 32'h0);
    @(posedge clk);
    #1;
    bus8.src_valid = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'h00, 1'b0, 8'h00, -1, -1);
    checkOutput("post rst cdb_valid", 32'(bus8.cdb_valid), 32'h0);
    checkOutput("post rst stall", stall8, 32'h0);

    // Five sources: reach rr=4, then wrap 4 -> 0.
    applyStimulus5(5'b01100, 5'b01100, 2, 3);
    applyStimulus5(5'b10001, 5'b10001, 4, 0);
    checkOutput("rr5 before wrap", 32'(dut5.rr_ptr), 32'd4);
    applyStimulus5(5'b11111, 5'b00110, 1, 2);
    checkOutput("rr5 after wrap", 32'(dut5.rr_ptr), 32'd1);
    checkOutput("stall5 no stall", stall5, 32'd0);
    applyStimulus5(5'b00000, 5'b00000, -1, -1);
    checkOutput("rr5 after 1,2", 32'(dut5.rr_ptr), 32'd3);
    checkOutput("stall5 after all", stall5, 32'd1);

    repeat (3) @(negedge clk);
    checkOutput("q8 drained", 32'(q8.size()), 32'd0);
    checkOutput("q5 drained", 32'(q5.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
